shift_frame_receiver: RTL and testbench

//   Serial-in/parallel-out frame receiver. It is the receive end of the serial stream that the

---
 rtl/shift_frame_receiver_if.sv | 25 ++
 rtl/shift_frame_receiver.sv | 115 +++++++++++
 tb/tb_shift_frame_receiver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_receiver_if.sv
// Parallel-side and serial-side signals of the frame receiver, bundled as one port.
// The master drives the line and the acknowledge; the slave is the receiver itself.
interface shift_frame_receiver_if #(
   parameter int WIDTH = 4
);
   logic             serial_in;
   logic             bit_en;
   logic             rd_ack;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic             parity_err;
   logic             overrun;
   logic             busy;

   modport master (
      output serial_in, bit_en, rd_ack,
      input  data_out, data_valid, frame_err, parity_err, overrun, busy
   );

   modport slave (
      input  serial_in, bit_en, rd_ack,
      output data_out, data_valid, frame_err, parity_err, overrun, busy
   );
endinterface

// File: rtl/shift_frame_receiver.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits LSB-first, optional
// parity bit, stop bit; the word is held for a valid/ack consumer with sticky error flags.
module shift_frame_receiver #(
   parameter int WIDTH  = 4,
   parameter int PARITY = 0
) (
   input  logic                  clk,
   input  logic                  clear,
   shift_frame_receiver_if.slave bus
);
   localparam int              CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic            ODD   = (PARITY == 2);

   typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, BRK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_pend_q, par_pend_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             parity_err_q, parity_err_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      par_pend_d   = par_pend_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;

      if (bus.rd_ack) begin
         data_valid_d = 1'b0;
         frame_err_d  = 1'b0;
         parity_err_d = 1'b0;
         overrun_d    = 1'b0;
      end

      if (bus.bit_en) begin
         unique case (state_q)
            IDLE: begin
               if (!bus.serial_in) begin
                  state_d    = DATA;
                  cnt_d      = '0;
                  par_pend_d = 1'b0;
               end
            end
            DATA: begin
               shift_d = {bus.serial_in, shift_q[WIDTH-1:1]};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = (PARITY != 0) ? PAR : STOP;
               end
            end
            PAR: begin
               par_pend_d = bus.serial_in ^ (^shift_q) ^ ODD;
               state_d    = STOP;
            end
            STOP: begin
               // Flags were already cleared above if rd_ack coincides, so OR-ing here
               // leaves only this word's errors and treats the old word as consumed.
               data_out_d   = shift_q;
               data_valid_d = 1'b1;
               overrun_d    = overrun_d | (data_valid_q & ~bus.rd_ack);
               frame_err_d  = frame_err_d | ~bus.serial_in;
               parity_err_d = parity_err_d | par_pend_q;
               state_d      = bus.serial_in ? IDLE : BRK;
            end
            BRK: begin
               if (bus.serial_in) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         par_pend_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         par_pend_q   <= par_pend_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.parity_err = parity_err_q;
   assign bus.overrun    = overrun_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_shift_frame_receiver.sv
// Directed bench for shift_frame_receiver: a frame-level model (collect whole frame, then
// decode) is compared every cycle, plus hand-computed literal expectations.
module tb_shift_frame_receiver;
   logic clk = 1'b0;
   logic clear = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic done = 1'b0;

   always #5 clk = ~clk;

   shift_frame_receiver_if #(.WIDTH(4)) if0 ();
   shift_frame_receiver_if #(.WIDTH(4)) if1 ();

   shift_frame_receiver #(.WIDTH(4), .PARITY(0)) dut0 (.clk(clk), .clear(clear), .bus(if0));
   shift_frame_receiver #(.WIDTH(4), .PARITY(1)) dut1 (.clk(clk), .clear(clear), .bus(if1));

   // phase: 0 = hunting for start, 1 = collecting frame bits, 2 = waiting for line high
   typedef struct {
      int          phase;
      int          n;
      logic [31:0] bits;
      logic [3:0]  dout;
      logic        valid;
      logic        ferr;
      logic        perr;
      logic        ovr;
   } model_t;

   model_t m0, m1;

   function automatic model_t model_reset();
      model_t m;
      m.phase = 0; m.n = 0; m.bits = '0; m.dout = '0;
      m.valid = 1'b0; m.ferr = 1'b0; m.perr = 1'b0; m.ovr = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(model_t mi, int par, logic sin, logic en, logic ack);
      model_t     m;
      int         nf;
      logic       commit;
      logic [3:0] w;
      logic       fe, pe, stop_bit;
      m      = mi;
      nf     = 4 + ((par != 0) ? 1 : 0) + 1;
      commit = 1'b0;
      w      = '0;
      fe     = 1'b0;
      pe     = 1'b0;
      if (en) begin
         if (m.phase == 0) begin
            if (!sin) begin
               m.phase = 1; m.n = 0; m.bits = '0;
            end
         end else if (m.phase == 1) begin
            m.bits[m.n] = sin;
            m.n = m.n + 1;
            if (m.n == nf) begin
               w        = m.bits[3:0];
               stop_bit = m.bits[nf-1];
               fe       = !stop_bit;
               pe       = (par != 0) && (m.bits[4] != ((^w) ^ (par == 2)));
               commit   = 1'b1;
               m.phase  = stop_bit ? 0 : 2;
            end
         end else begin
            if (sin) m.phase = 0;
         end
      end
      if (commit) begin
         m.dout = w;
         if (ack) begin
            m.ovr = 1'b0; m.ferr = fe; m.perr = pe;
         end else begin
            m.ovr = m.ovr | m.valid; m.ferr = m.ferr | fe; m.perr = m.perr | pe;
         end
         m.valid = 1'b1;
      end else if (ack) begin
         m.valid = 1'b0; m.ferr = 1'b0; m.perr = 1'b0; m.ovr = 1'b0;
      end
      return m;
   endfunction

   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         m0 <= model_reset();
         m1 <= model_reset();
      end else begin
         m0 <= model_step(m0, 0, if0.serial_in, if0.bit_en, if0.rd_ack);
         m1 <= model_step(m1, 1, if1.serial_in, if1.bit_en, if1.rd_ack);
      end
   end

   // Per-cycle comparison of every output of both instances against the model.
   always @(negedge clk) begin
      if (!done) begin
         logic [8:0] got0, exp0, got1, exp1;
         got0 = {if0.data_out, if0.data_valid, if0.frame_err, if0.parity_err, if0.overrun, if0.busy};
         exp0 = {m0.dout, m0.valid, m0.ferr, m0.perr, m0.ovr, (m0.phase != 0)};
         got1 = {if1.data_out, if1.data_valid, if1.frame_err, if1.parity_err, if1.overrun, if1.busy};
         exp1 = {m1.dout, m1.valid, m1.ferr, m1.perr, m1.ovr, (m1.phase != 0)};
         checks = checks + 2;
         if (got0 !== exp0) begin
            errors = errors + 1;
            $display("FAIL model_p0 t=%0t got {dout,v,fe,pe,ov,busy}=%b required %b", $time, got0, exp0);
         end
         if (got1 !== exp1) begin
            errors = errors + 1;
            $display("FAIL model_p1 t=%0t got {dout,v,fe,pe,ov,busy}=%b required %b", $time, got1, exp1);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end else begin
         $display("check %s = %0h ok", name, got);
      end
   endtask

   // One clock: drive selected instance, keep the other idle-high with strobes on.
   task automatic step(input int sel, input logic b, input logic en, input logic ack);
      if0.serial_in = (sel == 0) ? b : 1'b1;
      if0.bit_en    = (sel == 0) ? en : 1'b1;
      if0.rd_ack    = (sel == 0) ? ack : 1'b0;
      if1.serial_in = (sel == 1) ? b : 1'b1;
      if1.bit_en    = (sel == 1) ? en : 1'b1;
      if1.rd_ack    = (sel == 1) ? ack : 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic frame0(input logic [3:0] d, input logic stop_bit, input logic ack_on_stop);
      step(0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(0, d[i], 1'b1, 1'b0);
      step(0, stop_bit, 1'b1, ack_on_stop);
   endtask

   task automatic frame1(input logic [3:0] d, input logic pbit);
      step(1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1, d[i], 1'b1, 1'b0);
      step(1, pbit, 1'b1, 1'b0);
      step(1, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      logic [5:0] seq4;
      if0.serial_in = 1'b1; if0.bit_en = 1'b0; if0.rd_ack = 1'b0;
      if1.serial_in = 1'b1; if1.bit_en = 1'b0; if1.rd_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {23'd0, if0.data_out, if0.data_valid, if0.frame_err,
                            if0.parity_err, if0.overrun, if0.busy}, 32'd0);
      clear = 1'b1;

      // 1: good frame 4'hD
      $display("test 1: good frame");
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      frame0(4'hD, 1'b1, 1'b0);
      chk("t1_dout", {28'd0, if0.data_out}, 32'hD);
      chk("t1_valid", {31'd0, if0.data_valid}, 32'd1);
      chk("t1_flags", {29'd0, if0.frame_err, if0.parity_err, if0.overrun}, 32'd0);
      step(0, 1'b1, 1'b1, 1'b1);
      chk("t1_ack_valid", {31'd0, if0.data_valid}, 32'd0);

      // 2: stop bit low, line held low
      $display("test 2: framing error and break");
      frame0(4'hD, 1'b0, 1'b0);
      chk("t2_ferr", {31'd0, if0.frame_err}, 32'd1);
      chk("t2_dout", {28'd0, if0.data_out}, 32'hD);
      for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b1, 1'b0);
      chk("t2_brk_busy", {31'd0, if0.busy}, 32'd1);
      chk("t2_brk_no_overrun", {31'd0, if0.overrun}, 32'd0);
      step(0, 1'b1, 1'b1, 1'b1);
      chk("t2_idle", {30'd0, if0.busy, if0.frame_err}, 32'd0);

      // 3: overrun, then commit and ack on the same edge
      $display("test 3: overrun");
      frame0(4'h3, 1'b1, 1'b0);
      chk("t3_first", {28'd0, if0.data_out}, 32'h3);
      frame0(4'hA, 1'b1, 1'b0);
      chk("t3_dout", {28'd0, if0.data_out}, 32'hA);
      chk("t3_ovr", {31'd0, if0.overrun}, 32'd1);
      step(0, 1'b1, 1'b1, 1'b1);
      frame0(4'h3, 1'b1, 1'b0);
      frame0(4'hA, 1'b1, 1'b1);
      chk("t3_ack_commit", {29'd0, if0.overrun, if0.data_valid, if0.frame_err}, 32'b010);
      step(0, 1'b1, 1'b1, 1'b1);

      // 4: strobe every third clock, garbage on the line between strobes
      $display("test 4: sparse strobes");
      seq4 = 6'b101100;
      for (int i = 0; i < 6; i++) begin
         step(0, seq4[i], 1'b1, 1'b0);
         step(0, ~seq4[i], 1'b0, 1'b0);
         step(0, ~seq4[i], 1'b0, 1'b0);
         if (i == 0) chk("t4_hold_busy", {31'd0, if0.busy}, 32'd1);
      end
      chk("t4_dout", {28'd0, if0.data_out}, 32'h6);
      chk("t4_valid", {31'd0, if0.data_valid}, 32'd1);

      // 5: asynchronous reset mid-frame, then a clean frame
      $display("test 5: reset mid-frame");
      step(0, 1'b0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b0, 1'b1, 1'b0);
      chk("t5_pre_busy", {31'd0, if0.busy}, 32'd1);
      #2;
      clear = 1'b0;
      #1;
      chk("t5_cleared", {23'd0, if0.data_out, if0.data_valid, if0.frame_err,
                         if0.parity_err, if0.overrun, if0.busy}, 32'd0);
      step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1, 1'b0);
      clear = 1'b1;
      frame0(4'h9, 1'b1, 1'b0);
      chk("t5_dout", {28'd0, if0.data_out}, 32'h9);
      chk("t5_valid", {31'd0, if0.data_valid}, 32'd1);

      // 6: even parity instance
      $display("test 6: even parity");
      frame1(4'hD, 1'b1);
      chk("t6_dout", {28'd0, if1.data_out}, 32'hD);
      chk("t6_perr_ok", {31'd0, if1.parity_err}, 32'd0);
      step(1, 1'b1, 1'b1, 1'b1);
      frame1(4'hD, 1'b0);
      chk("t6_perr_bad", {31'd0, if1.parity_err}, 32'd1);
      chk("t6_p0_perr", {31'd0, if0.parity_err}, 32'd0);
      step(1, 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
